banked_stack_address_unit: RTL
==============================

Name: banked_stack_address_unit

Overview:
Sequential successor to the combinational memory address handler. Holds banked kernel/user stack pointers in registers and accepts commands over a valid/ready handshake. Generates multi-word PUSH/POP bursts, one memory address per beat, with atomic overflow/underflow checking. Sits between the control unit and the data-memory port; the control unit no longer loops over single-word stack operations.

Parameters:
ADDR_WIDTH, 32, memory address width
DATA_WIDTH, 32, SP / input_address width
KERNEL_STACK_TOP, 4096, lowest valid kernel stack word
KERNEL_STACK_BOTTOM, 6143, highest valid kernel stack word
USER_STACK_TOP, 6144, lowest valid user stack word
USER_STACK_BOTTOM, 8191, highest valid user stack word
MAX_BURST, 8, maximum words per PUSH/POP
COUNT_WIDTH, 4, width of burst_count; must hold MAX_BURST

Ports:
clock  in  1  system clock
reset  in  1  asynchronous, active-low reset
cmd_valid  in  1  command present
cmd_ready  out  1  unit can accept a command (high only in IDLE)
control  in  3  0 ADDR, 1 PUSH, 2 POP, 3 SETSP; 4-7 are treated as ADDR
is_kernel  in  1  bank select, sampled on accept
burst_count  in  COUNT_WIDTH  words for PUSH/POP
input_address  in  DATA_WIDTH  address for ADDR, new SP for SETSP
mem_valid  out  1  mem_address valid this cycle
mem_ready  in  1  memory accepts the beat
mem_address  out  ADDR_WIDTH  beat address
sp_out  out  DATA_WIDTH  SP of the bank selected by is_kernel (latched bank while busy)
done  out  1  one-cycle pulse on command completion
fault  out  1  one-cycle pulse on rejected command
fault_code  out  2  sticky code: 0 none, 1 overflow, 2 underflow, 3 bad SETSP or burst

Behaviour:
- Stack model: full-descending. An empty stack has SP = BOTTOM+1 (kernel 6144, user 8192). Full when SP == TOP.
- Reset (reset=0, asynchronous): kernel_sp=KERNEL_STACK_BOTTOM+1, user_sp=USER_STACK_BOTTOM+1, state=IDLE. mem_valid, done, fault = 0; fault_code = 0; mem_address = 0. Reset mid-burst aborts the burst and drops mem_valid immediately. No SP update is kept.
- Accept: when cmd_valid && cmd_ready. control, is_kernel, burst_count, input_address and the selected SP are latched. fault_code clears on accept.
- Range checks are done at accept, in ADDR_WIDTH+1 bits so there is no wrap:
  - PUSH n faults (code 1) if SP-n < TOP.
  - POP n faults (code 2) if SP+n > BOTTOM+1.
  - PUSH/POP with n > MAX_BURST faults (code 3).
  - SETSP faults (code 3) if input_address is outside [TOP, BOTTOM+1].
  - A faulted command is atomic: no beats, SP unchanged. It goes IDLE->FAULT->IDLE, with fault high for 1 cycle.
- States: IDLE, BURST, DONE, FAULT.
  - IDLE: accept leads to FAULT, to BURST (ADDR; PUSH/POP with n>0), or to DONE (SETSP; PUSH/POP with n=0).
  - BURST: mem_valid=1. A beat retires on mem_valid && mem_ready. mem_ready=0 stalls with address held stable.
  - After the last beat retires, go to DONE. DONE drives done=1 for one cycle, then returns to IDLE.
- Beat addresses (beat k = 0..n-1), ascending:
  - PUSH: SP-n+k.
  - POP: SP+k.
  - ADDR: one beat at input_address[ADDR_WIDTH-1:0].
- SP update happens on the clock edge that retires the last beat: PUSH gives SP-n, POP gives SP+n. SETSP writes on the accept edge. ADDR leaves SP unchanged.
- sp_out shows the new value no later than the cycle done is asserted. Only the latched bank is written; the other bank never changes.
- Minimum latency: accept to first beat is 1 cycle; last beat retire to done is 1 cycle. cmd_ready is low from the accept edge until back in IDLE.

Decomposition:
- Shared package stack_pkg holds:
  - command encodings CMD_ADDR/PUSH/POP/SETSP;
  - fault codes FAULT_NONE/OVF/UNF/BAD;
  - the state encoding;
  - the empty-SP constants.
- Sub-module stack_bounds_checker: combinational. Takes SP, n, TOP, BOTTOM and setsp value; outputs overflow, underflow, bad.

Test Plan:
- After reset, cmd PUSH n=3 with is_kernel=1, mem_ready=1: beats at 6141, 6142, 6143; done 1 cycle later; kernel sp_out=6141; user SP stays 8192.
- POP n=3 from kernel SP 6141 with mem_ready low 2 cycles on beat 1: addresses 6141, 6142(held 3 cycles), 6143; SP=6144 at done.
- SETSP user 6146, then PUSH n=3: fault, fault_code=1, no mem_valid, SP stays 6146; the next accepted ADDR clears fault_code to 0.
- POP n=1 on empty user stack (8192): fault_code=2. SETSP 9000: fault_code=3. PUSH n=9: fault_code=3.
- ADDR with input_address=0x1234: single beat at 0x1234; SPs unchanged; PUSH n=0: done with no beats.
- Assert reset mid-burst on beat 2 of a PUSH of 5 words: mem_valid drops without waiting for clock; both SPs return to 6144/8192; cmd_ready=1 after release.

Source files
------------

// File: rtl/stack_pkg.sv
// Shared encodings for the banked stack address unit: commands, fault codes,
// FSM states and the default empty-stack pointers.
package stack_pkg;

    localparam int unsigned CMD_W   = 3;
    localparam int unsigned FAULT_W = 2;
    localparam int unsigned STATE_W = 2;

    localparam logic [CMD_W-1:0] CMD_ADDR  = 3'd0;
    localparam logic [CMD_W-1:0] CMD_PUSH  = 3'd1;
    localparam logic [CMD_W-1:0] CMD_POP   = 3'd2;
    localparam logic [CMD_W-1:0] CMD_SETSP = 3'd3;

    localparam logic [FAULT_W-1:0] FAULT_NONE = 2'd0;
    localparam logic [FAULT_W-1:0] FAULT_OVF  = 2'd1;
    localparam logic [FAULT_W-1:0] FAULT_UNF  = 2'd2;
    localparam logic [FAULT_W-1:0] FAULT_BAD  = 2'd3;

    localparam logic [STATE_W-1:0] ST_IDLE  = 2'd0;
    localparam logic [STATE_W-1:0] ST_BURST = 2'd1;
    localparam logic [STATE_W-1:0] ST_DONE  = 2'd2;
    localparam logic [STATE_W-1:0] ST_FAULT = 2'd3;

    localparam int unsigned KERNEL_EMPTY_SP = 6144;
    localparam int unsigned USER_EMPTY_SP   = 8192;

    // Latched command: operation and bank it applies to.
    typedef struct packed {
        logic [CMD_W-1:0] op;
        logic             is_kernel;
    } cmd_t;

    // Encodings 4-7 are aliases of ADDR.
    function automatic logic [CMD_W-1:0] decode_cmd(input logic [CMD_W-1:0] raw);
        return (raw > CMD_SETSP) ? CMD_ADDR : raw;
    endfunction

endpackage

// File: rtl/stack_bounds_checker.sv
// Combinational range checks for one stack command, evaluated one bit wider
// than the address so that SP +/- n can never wrap.
module stack_bounds_checker
    import stack_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH  = 32,
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned COUNT_WIDTH = 4,
    parameter int unsigned MAX_BURST   = 8
) (
    input  logic [CMD_W-1:0]       cmd,
    input  logic [DATA_WIDTH-1:0]  sp,
    input  logic [COUNT_WIDTH-1:0] n,
    input  logic [DATA_WIDTH-1:0]  top,
    input  logic [DATA_WIDTH-1:0]  bottom,
    input  logic [DATA_WIDTH-1:0]  setsp_value,
    output logic                   overflow,
    output logic                   underflow,
    output logic                   bad
);

    localparam int unsigned CW = ADDR_WIDTH + 1;

    logic [CW-1:0] sp_w;
    logic [CW-1:0] n_w;
    logic [CW-1:0] top_w;
    logic [CW-1:0] limit_w;
    logic [CW-1:0] value_w;
    logic          is_push;
    logic          is_pop;
    logic          is_setsp;
    logic          burst_too_long;
    logic          setsp_out_of_range;

    assign sp_w    = CW'(sp);
    assign n_w     = CW'(n);
    assign top_w   = CW'(top);
    assign limit_w = CW'(bottom) + CW'(1);
    assign value_w = CW'(setsp_value);

    assign is_push  = (cmd == CMD_PUSH);
    assign is_pop   = (cmd == CMD_POP);
    assign is_setsp = (cmd == CMD_SETSP);

    // SP - n < TOP rewritten as SP < TOP + n to avoid an underflowing subtract.
    assign overflow  = is_push && (sp_w < top_w + n_w);
    assign underflow = is_pop && (sp_w + n_w > limit_w);

    assign burst_too_long     = (is_push || is_pop) && (32'(n) > 32'(MAX_BURST));
    assign setsp_out_of_range = is_setsp && ((value_w < top_w) || (value_w > limit_w));
    assign bad                = burst_too_long || setsp_out_of_range;

endmodule

// File: rtl/banked_stack_address_unit.sv
// Banked kernel/user stack pointer unit: accepts commands over valid/ready and
// emits one memory address per beat for PUSH/POP bursts and single ADDR beats.
module banked_stack_address_unit
    import stack_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH          = 32,
    parameter int unsigned DATA_WIDTH          = 32,
    parameter int unsigned KERNEL_STACK_TOP    = 4096,
    parameter int unsigned KERNEL_STACK_BOTTOM = KERNEL_EMPTY_SP - 1,
    parameter int unsigned USER_STACK_TOP      = 6144,
    parameter int unsigned USER_STACK_BOTTOM   = USER_EMPTY_SP - 1,
    parameter int unsigned MAX_BURST           = 8,
    parameter int unsigned COUNT_WIDTH         = 4
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   cmd_valid,
    output logic                   cmd_ready,
    input  logic [CMD_W-1:0]       control,
    input  logic                   is_kernel,
    input  logic [COUNT_WIDTH-1:0] burst_count,
    input  logic [DATA_WIDTH-1:0]  input_address,
    output logic                   mem_valid,
    input  logic                   mem_ready,
    output logic [ADDR_WIDTH-1:0]  mem_address,
    output logic [DATA_WIDTH-1:0]  sp_out,
    output logic                   done,
    output logic                   fault,
    output logic [FAULT_W-1:0]     fault_code
);

    localparam logic [DATA_WIDTH-1:0] K_EMPTY  = DATA_WIDTH'(KERNEL_STACK_BOTTOM + 1);
    localparam logic [DATA_WIDTH-1:0] U_EMPTY  = DATA_WIDTH'(USER_STACK_BOTTOM + 1);
    localparam logic [DATA_WIDTH-1:0] K_TOP    = DATA_WIDTH'(KERNEL_STACK_TOP);
    localparam logic [DATA_WIDTH-1:0] K_BOTTOM = DATA_WIDTH'(KERNEL_STACK_BOTTOM);
    localparam logic [DATA_WIDTH-1:0] U_TOP    = DATA_WIDTH'(USER_STACK_TOP);
    localparam logic [DATA_WIDTH-1:0] U_BOTTOM = DATA_WIDTH'(USER_STACK_BOTTOM);

    logic [STATE_W-1:0]     state,        state_nxt;
    logic [DATA_WIDTH-1:0]  kernel_sp,    kernel_sp_nxt;
    logic [DATA_WIDTH-1:0]  user_sp,      user_sp_nxt;
    logic [DATA_WIDTH-1:0]  target_sp,    target_sp_nxt;
    cmd_t                   cmd_q,        cmd_nxt;
    logic [COUNT_WIDTH-1:0] beats_left,   beats_left_nxt;
    logic [ADDR_WIDTH-1:0]  mem_address_nxt;
    logic                   mem_valid_nxt;
    logic                   done_nxt;
    logic                   fault_nxt;
    logic [FAULT_W-1:0]     fault_code_nxt;
    logic                   cmd_ready_nxt;
    logic [DATA_WIDTH-1:0]  sp_out_nxt;
    logic                   out_bank;

    logic [CMD_W-1:0]       op;
    logic [DATA_WIDTH-1:0]  sel_sp;
    logic [DATA_WIDTH-1:0]  sel_top;
    logic [DATA_WIDTH-1:0]  sel_bottom;
    logic [DATA_WIDTH-1:0]  n_ext;
    logic                   overflow;
    logic                   underflow;
    logic                   bad;

    assign op         = decode_cmd(control);
    assign sel_sp     = is_kernel ? kernel_sp : user_sp;
    assign sel_top    = is_kernel ? K_TOP : U_TOP;
    assign sel_bottom = is_kernel ? K_BOTTOM : U_BOTTOM;
    assign n_ext      = DATA_WIDTH'(burst_count);

    stack_bounds_checker #(
        .ADDR_WIDTH  (ADDR_WIDTH),
        .DATA_WIDTH  (DATA_WIDTH),
        .COUNT_WIDTH (COUNT_WIDTH),
        .MAX_BURST   (MAX_BURST)
    ) u_bounds (
        .cmd         (op),
        .sp          (sel_sp),
        .n           (burst_count),
        .top         (sel_top),
        .bottom      (sel_bottom),
        .setsp_value (input_address),
        .overflow    (overflow),
        .underflow   (underflow),
        .bad         (bad)
    );

    // State and output registers; reset aborts any burst in flight.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state       <= ST_IDLE;
            kernel_sp   <= K_EMPTY;
            user_sp     <= U_EMPTY;
            target_sp   <= '0;
            cmd_q       <= '0;
            beats_left  <= '0;
            mem_address <= '0;
            mem_valid   <= 1'b0;
            done        <= 1'b0;
            fault       <= 1'b0;
            fault_code  <= FAULT_NONE;
            cmd_ready   <= 1'b1;
            sp_out      <= K_EMPTY;
        end else begin
            state       <= state_nxt;
            kernel_sp   <= kernel_sp_nxt;
            user_sp     <= user_sp_nxt;
            target_sp   <= target_sp_nxt;
            cmd_q       <= cmd_nxt;
            beats_left  <= beats_left_nxt;
            mem_address <= mem_address_nxt;
            mem_valid   <= mem_valid_nxt;
            done        <= done_nxt;
            fault       <= fault_nxt;
            fault_code  <= fault_code_nxt;
            cmd_ready   <= cmd_ready_nxt;
            sp_out      <= sp_out_nxt;
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_nxt       = state;
        kernel_sp_nxt   = kernel_sp;
        user_sp_nxt     = user_sp;
        target_sp_nxt   = target_sp;
        cmd_nxt         = cmd_q;
        beats_left_nxt  = beats_left;
        mem_address_nxt = mem_address;
        mem_valid_nxt   = 1'b0;
        done_nxt        = 1'b0;
        fault_nxt       = 1'b0;
        fault_code_nxt  = fault_code;

        case (state)
            ST_IDLE: begin
                if (cmd_valid) begin
                    cmd_nxt.op        = op;
                    cmd_nxt.is_kernel = is_kernel;
                    fault_code_nxt    = FAULT_NONE;
                    target_sp_nxt     = sel_sp;
                    if (bad || overflow || underflow) begin
                        fault_code_nxt = bad ? FAULT_BAD : (overflow ? FAULT_OVF : FAULT_UNF);
                        fault_nxt      = 1'b1;
                        state_nxt      = ST_FAULT;
                    end else begin
                        case (op)
                            CMD_PUSH, CMD_POP: begin
                                target_sp_nxt   = (op == CMD_PUSH) ? sel_sp - n_ext : sel_sp + n_ext;
                                mem_address_nxt = (op == CMD_PUSH) ? ADDR_WIDTH'(sel_sp - n_ext)
                                                                   : ADDR_WIDTH'(sel_sp);
                                beats_left_nxt  = burst_count;
                                if (burst_count == '0) begin
                                    done_nxt  = 1'b1;
                                    state_nxt = ST_DONE;
                                end else begin
                                    mem_valid_nxt = 1'b1;
                                    state_nxt     = ST_BURST;
                                end
                            end
                            CMD_SETSP: begin
                                if (is_kernel) begin
                                    kernel_sp_nxt = input_address;
                                end else begin
                                    user_sp_nxt = input_address;
                                end
                                done_nxt  = 1'b1;
                                state_nxt = ST_DONE;
                            end
                            default: begin
                                mem_address_nxt = input_address[ADDR_WIDTH-1:0];
                                beats_left_nxt  = COUNT_WIDTH'(1);
                                mem_valid_nxt   = 1'b1;
                                state_nxt       = ST_BURST;
                            end
                        endcase
                    end
                end
            end
            ST_BURST: begin
                mem_valid_nxt = 1'b1;
                if (mem_ready) begin
                    if (beats_left == COUNT_WIDTH'(1)) begin
                        mem_valid_nxt = 1'b0;
                        done_nxt      = 1'b1;
                        state_nxt     = ST_DONE;
                        // SP commits only when the whole burst has retired.
                        if (cmd_q.op == CMD_PUSH || cmd_q.op == CMD_POP) begin
                            if (cmd_q.is_kernel) begin
                                kernel_sp_nxt = target_sp;
                            end else begin
                                user_sp_nxt = target_sp;
                            end
                        end
                    end else begin
                        beats_left_nxt  = beats_left - COUNT_WIDTH'(1);
                        mem_address_nxt = mem_address + ADDR_WIDTH'(1);
                    end
                end
            end
            ST_DONE:  state_nxt = ST_IDLE;
            ST_FAULT: state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase

        cmd_ready_nxt = (state_nxt == ST_IDLE);
        out_bank      = (state_nxt == ST_IDLE) ? is_kernel : cmd_nxt.is_kernel;
        sp_out_nxt    = out_bank ? kernel_sp_nxt : user_sp_nxt;
    end

endmodule
